fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock, clk (rising edge), and an asynchronous active-low reset, reset_n.
REQ-002 Parameter NOP_INST, 16'h0000, IR value loaded on bubble/flush/redirect/reset.
REQ-003 Ports SHALL be:
 clk  in  1  clock
 reset_n  in  1  async active-low reset
 pc_write  in  1  hazard unit: PC may advance
 ir_write  in  1  hazard unit: IR may load
 flush_if  in  1  hazard unit: discard instruction being fetched
 incr_num_inst  in  1  hazard unit: count retired-into-ID instruction
 redirect_valid  in  1  EX: branch/jump resolved, change PC
 redirect_target  in  16  EX: new PC
 i_readM  out  1  instruction memory read request
 i_address  out  16  instruction memory word address
 i_data  in  16  instruction memory read data
 i_input_ready  in  1  i_data valid this cycle
 ir  out  16  IF/ID instruction register
 ir_valid  out  1  ir holds a real instruction
 pc_id  out  16  PC+1 of instruction in ir
 fetch_stall  out  1  request outstanding, no data this cycle
 num_inst  out  16  instruction counter

Function
REQ-004 States SHALL be IDLE, REQ, HOLD; registered PC (16b), fetch buffer (16b).
REQ-005 IDLE: i_readM=0; unconditionally -> REQ next cycle.
REQ-006 REQ: i_readM=1, i_address=PC; fetch_stall=!i_input_ready; HOLD/IDLE: fetch_stall=0.
REQ-007 advance SHALL be defined as ir_write && pc_write; either low alone = hold (PC, IR, state unchanged except REQ->HOLD capture).
REQ-008 REQ with i_input_ready and advance: ir<=i_data, ir_valid<=1, pc_id<=PC+1, PC<=PC+1, stay REQ (next request issued next cycle).
REQ-009 REQ with i_input_ready and no advance: buffer<=i_data, -> HOLD; PC, ir unchanged.
REQ-010 REQ without i_input_ready and advance: ir<=NOP_INST, ir_valid<=0 (bubble), PC unchanged, stay REQ.
REQ-011 HOLD: i_readM=0; on advance ir<=buffer, ir_valid<=1, pc_id<=PC+1, PC<=PC+1, -> REQ; else hold.
REQ-012 flush_if=1 (no redirect): ir<=NOP_INST, ir_valid<=0, data returned this cycle and buffer discarded, PC unchanged, -> REQ (same PC re-fetched).
REQ-013 redirect_valid=1: PC<=redirect_target, ir<=NOP_INST, ir_valid<=0, buffer discarded, any i_data this cycle ignored, -> REQ.
REQ-014 Priority: reset > redirect_valid > flush_if > advance/hold.
REQ-015 PC+1 SHALL wrap 16'hFFFF -> 16'h0000; pc_id likewise.
REQ-016 num_inst SHALL increment by 1 on each clock with incr_num_inst=1 and ir_valid=1, wrapping 16'hFFFF -> 0.
REQ-017 Memory latency SHALL be arbitrary (>=0 wait cycles); i_address stable while in REQ until i_input_ready or redirect.
REQ-018 Instruction at PC SHALL appear in ir the cycle after i_input_ready when advance=1.

Reset
REQ-019 reset_n low SHALL immediately force: state=IDLE, PC=0, ir=NOP_INST, ir_valid=0, pc_id=0, buffer=0, num_inst=0, i_readM=0.
REQ-020 Reset mid-fetch SHALL abandon the request; i_input_ready during reset ignored.
REQ-021 After reset_n rises, first request (i_address=0) SHALL be issued on the second rising edge.

Verification
REQ-022 Reset release, zero-latency memory returning 16'h1234 at addr 0, advance=1 -> ir=16'h1234, ir_valid=1, pc_id=1, next i_address=1.
REQ-023 2-cycle memory latency, advance=1 -> fetch_stall=1 two cycles, two bubbles (ir=NOP_INST, ir_valid=0), then instruction loads, PC advances once.
REQ-024 Data 16'hABCD returns with ir_write=pc_write=0 for 3 cycles -> HOLD, i_readM=0, ir unchanged; on release ir=16'hABCD, PC+1.
REQ-025 flush_if=1 same cycle as data at PC=5 -> ir_valid=0, PC stays 5, i_address=5 re-requested; redirect_valid with target 16'h0040 simultaneous with flush_if and i_input_ready -> PC=16'h0040, ir_valid=0.
REQ-026 PC=16'hFFFF fetch with advance -> PC=0, pc_id=0; incr_num_inst held 3 cycles with ir_valid=1 from num_inst=16'hFFFE -> 16'h0001.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues requests to instruction memory, tolerates
// arbitrary memory latency, and loads the IF/ID register under hazard-unit control.
module fetch_unit #(
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_write,
  input  logic        ir_write,
  input  logic        flush_if,
  input  logic        incr_num_inst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic [15:0] i_data,
  input  logic        i_input_ready,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic [15:0] pc_id,
  output logic        fetch_stall,
  output logic [15:0] num_inst
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic [15:0] pc_inc;
  logic [15:0] buffer;
  logic [15:0] buffer_next;
  logic [15:0] ir_next;
  logic        ir_valid_next;
  logic [15:0] pc_id_next;
  logic [15:0] num_inst_next;
  logic        advance;

  // Both hazard enables must be high to move an instruction into ID.
  assign advance = ir_write && pc_write;
  assign pc_inc  = pc + 16'd1;

  assign i_readM     = (state == REQ);
  assign i_address   = pc;
  assign fetch_stall = (state == REQ) && !i_input_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= 16'h0000;
      buffer   <= 16'h0000;
      ir       <= NOP_INST;
      ir_valid <= 1'b0;
      pc_id    <= 16'h0000;
      num_inst <= 16'h0000;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      buffer   <= buffer_next;
      ir       <= ir_next;
      ir_valid <= ir_valid_next;
      pc_id    <= pc_id_next;
      num_inst <= num_inst_next;
    end
  end

  // Redirect outranks flush, which outranks the normal advance/hold behaviour.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    buffer_next   = buffer;
    ir_next       = ir;
    ir_valid_next = ir_valid;
    pc_id_next    = pc_id;

    if (redirect_valid) begin
      pc_next       = redirect_target;
      ir_next       = NOP_INST;
      ir_valid_next = 1'b0;
      buffer_next   = 16'h0000;
      state_next    = REQ;
    end else if (flush_if) begin
      ir_next       = NOP_INST;
      ir_valid_next = 1'b0;
      buffer_next   = 16'h0000;
      state_next    = REQ;
    end else begin
      case (state)
        IDLE: begin
          state_next = REQ;
        end
        REQ: begin
          if (i_input_ready) begin
            if (advance) begin
              ir_next       = i_data;
              ir_valid_next = 1'b1;
              pc_id_next    = pc_inc;
              pc_next       = pc_inc;
            end else begin
              buffer_next = i_data;
              state_next  = HOLD;
            end
          end else if (advance) begin
            ir_next       = NOP_INST;
            ir_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            ir_next       = buffer;
            ir_valid_next = 1'b1;
            pc_id_next    = pc_inc;
            pc_next       = pc_inc;
            state_next    = REQ;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    num_inst_next = num_inst;
    if (incr_num_inst && ir_valid) begin
      num_inst_next = num_inst + 16'd1;
    end
  end

endmodule
